// File: rtl/viterbi_stream_core_if.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_stream_core_if
// Description : Sample-in / decision-out valid-ready stream bundle for the
//               streaming Viterbi MLSE core.
// Revision    : 1.0 - initial release
// ============================================================================
interface viterbi_stream_core_if #(
    parameter int B_WIDTH = 8
) ();
    logic                      in_valid;
    logic                      in_ready;
    logic signed [B_WIDTH-1:0] in_sample;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [1:0]         out_symbol;

    modport master (
        output in_valid, in_sample, out_ready,
        input  in_ready, out_valid, out_symbol
    );

    modport slave (
        input  in_valid, in_sample, out_ready,
        output in_ready, out_valid, out_symbol
    );
endinterface
`default_nettype wire

// File: rtl/viterbi_stream_core.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_stream_core
// Description : Streaming one-sample-per-cycle Viterbi MLSE detector for +/-1
//               symbols over a CHAN_LEN-tap FIR channel, register-exchange
//               survivors and normalised path metrics.
// Revision    : 1.0 - initial release
// ============================================================================
module viterbi_stream_core #(
    parameter int B_WIDTH           = 8,
    parameter int CHAN_LEN          = 3,
    parameter int EST_CHANNEL_WIDTH = 8,
    parameter int TB_DEPTH          = 16,
    parameter int PM_WIDTH          = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [CHAN_LEN*EST_CHANNEL_WIDTH-1:0] est_channel,
    input  logic                                  update,
    output logic                                  busy,
    viterbi_stream_core_if.slave                  s_if
);

    localparam int NUM_STATES = 1 << (CHAN_LEN - 1);
    localparam int NUM_EV     = 2 * NUM_STATES;
    localparam int ST_W       = CHAN_LEN - 1;
    localparam int EV_W       = EST_CHANNEL_WIDTH + $clog2(CHAN_LEN) + 1;
    localparam int DIFF_W     = ((EV_W > B_WIDTH) ? EV_W : B_WIDTH) + 1;
    localparam int SQ_W       = 2 * DIFF_W;
    localparam int FILL_W     = $clog2(TB_DEPTH + 1);

    localparam logic [PM_WIDTH-1:0] PM_MAX  = '1;
    localparam logic [CHAN_LEN-1:0] K_LAST  = '1;
    localparam logic signed [1:0]   SYM_POS = 2'sb01;
    localparam logic signed [1:0]   SYM_NEG = 2'sb11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRECOMP = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    state_e                          state_q, state_d;
    logic [CHAN_LEN-1:0]             k_q, k_d;
    logic signed [EST_CHANNEL_WIDTH-1:0] taps_q [CHAN_LEN];
    logic signed [EV_W-1:0]          ev_q   [NUM_EV];
    logic [PM_WIDTH-1:0]             pm_q   [NUM_STATES];
    logic [TB_DEPTH-1:0]             surv_q [NUM_STATES];
    logic [FILL_W-1:0]               fill_q;
    logic                            out_valid_q;
    logic signed [1:0]               out_symbol_q;

    logic                            w_in_ready;
    logic                            w_accept;
    logic signed [EV_W-1:0]          w_ev_k;
    logic [NUM_STATES-1:0]           w_take_b;
    logic [PM_WIDTH-1:0]             w_cand_sel [NUM_STATES];
    logic [TB_DEPTH-1:0]             w_surv_new [NUM_STATES];
    logic [PM_WIDTH-1:0]             w_min;
    logic [ST_W-1:0]                 w_best;
    logic                            w_decision;
    logic                            w_fill_ready;

    function automatic logic [PM_WIDTH-1:0] sat_add(
        input logic [PM_WIDTH-1:0] a,
        input logic [PM_WIDTH-1:0] b
    );
        logic [PM_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[PM_WIDTH] ? PM_MAX : sum[PM_WIDTH-1:0];
    endfunction

    // Squared Euclidean distance, clipped to the metric range.
    function automatic logic [PM_WIDTH-1:0] branch_metric(
        input logic signed [B_WIDTH-1:0] y,
        input logic signed [EV_W-1:0]    ev
    );
        logic signed [DIFF_W-1:0] diff;
        logic signed [SQ_W-1:0]   wide;
        logic [SQ_W-1:0]          sq;
        diff = DIFF_W'(y) - DIFF_W'(ev);
        wide = SQ_W'(diff);
        sq   = $unsigned(wide * wide);
        return (sq > SQ_W'(PM_MAX)) ? PM_MAX : sq[PM_WIDTH-1:0];
    endfunction

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        w_in_ready = 1'b0;
        busy       = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (update) begin
                    state_d = ST_PRECOMP;
                    k_d     = '0;
                end
            end
            ST_PRECOMP: begin
                k_d = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy       = 1'b0;
                w_in_ready = !out_valid_q || s_if.out_ready;
            end
            default: state_d = ST_IDLE;
        endcase
        // A new channel estimate pre-empts everything, including a sample
        // being offered in the same cycle.
        if (update) begin
            state_d    = ST_PRECOMP;
            k_d        = '0;
            w_in_ready = 1'b0;
        end
    end

    assign w_accept = s_if.in_valid && w_in_ready;

    // Expected noiseless output for transition index k: bit i of k is x[n-i].
    always_comb begin
        w_ev_k = '0;
        for (int i = 0; i < CHAN_LEN; i++) begin
            if (k_q[i]) begin
                w_ev_k = w_ev_k + EV_W'(taps_q[i]);
            end else begin
                w_ev_k = w_ev_k - EV_W'(taps_q[i]);
            end
        end
    end

    // ------------------------------------------------------------------ ACS
    for (genvar t = 0; t < NUM_STATES; t++) begin : g_acs
        localparam int PA  = t >> 1;
        localparam int PB  = PA + NUM_STATES / 2;
        localparam int BIT = t % 2;

        logic [PM_WIDTH-1:0] w_cand_a;
        logic [PM_WIDTH-1:0] w_cand_b;

        assign w_cand_a = sat_add(pm_q[PA], branch_metric(s_if.in_sample, ev_q[2*PA+BIT]));
        assign w_cand_b = sat_add(pm_q[PB], branch_metric(s_if.in_sample, ev_q[2*PB+BIT]));
        // Strict compare so a tie resolves towards the lower predecessor.
        assign w_take_b[t]   = w_cand_b < w_cand_a;
        assign w_cand_sel[t] = w_take_b[t] ? w_cand_b : w_cand_a;
        assign w_surv_new[t] = {(w_take_b[t] ? surv_q[PB][TB_DEPTH-2:0]
                                             : surv_q[PA][TB_DEPTH-2:0]), 1'(BIT)};
    end

    always_comb begin
        w_min  = w_cand_sel[0];
        w_best = '0;
        for (int t = 1; t < NUM_STATES; t++) begin
            if (w_cand_sel[t] < w_min) begin
                w_min  = w_cand_sel[t];
                w_best = ST_W'(t);
            end
        end
    end

    assign w_decision   = w_surv_new[w_best][TB_DEPTH-1];
    assign w_fill_ready = fill_q >= FILL_W'(TB_DEPTH - 1);

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHAN_LEN; i++) begin
                taps_q[i] <= '0;
            end
            for (int k = 0; k < NUM_EV; k++) begin
                ev_q[k] <= '0;
            end
            for (int t = 0; t < NUM_STATES; t++) begin
                pm_q[t]   <= '0;
                surv_q[t] <= '0;
            end
            fill_q       <= '0;
            out_valid_q  <= 1'b0;
            out_symbol_q <= '0;
        end else begin
            if (update) begin
                for (int i = 0; i < CHAN_LEN; i++) begin
                    taps_q[i] <= est_channel[i*EST_CHANNEL_WIDTH +: EST_CHANNEL_WIDTH];
                end
            end
            if (state_q == ST_PRECOMP) begin
                ev_q[k_q] <= w_ev_k;
            end
            // Trellis is held cleared for the whole precompute, so RUN always
            // starts from a blank slate and stale decisions are dropped.
            if (update || state_q == ST_PRECOMP) begin
                for (int t = 0; t < NUM_STATES; t++) begin
                    pm_q[t]   <= '0;
                    surv_q[t] <= '0;
                end
                fill_q      <= '0;
                out_valid_q <= 1'b0;
            end else if (w_accept) begin
                for (int t = 0; t < NUM_STATES; t++) begin
                    pm_q[t]   <= w_cand_sel[t] - w_min;
                    surv_q[t] <= w_surv_new[t];
                end
                if (fill_q != FILL_W'(TB_DEPTH)) begin
                    fill_q <= fill_q + 1'b1;
                end
                out_valid_q <= w_fill_ready;
                if (w_fill_ready) begin
                    out_symbol_q <= w_decision ? SYM_POS : SYM_NEG;
                end
            end else if (s_if.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign s_if.in_ready   = w_in_ready;
    assign s_if.out_valid  = out_valid_q;
    assign s_if.out_symbol = out_symbol_q;

endmodule
`default_nettype wire
